// File: rtl/ode_mem_pkg.sv
// Shared constants for the ODE solver memory subsystem: arbiter state
// encodings, requester indices and default bus widths.
package ode_mem_pkg;

    localparam int DEFAULT_AW       = 13;
    localparam int DEFAULT_DW       = 32;
    localparam int DEFAULT_MAX_HOLD = 64;

    localparam int OWNER_IO   = 0;
    localparam int OWNER_CORE = 1;

    // One-hot owner encoding so the state register doubles as the grant vector.
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_IDLE     = 2'b00;
    localparam arb_state_t ST_OWN_IO   = 2'b01;
    localparam arb_state_t ST_OWN_CORE = 2'b10;

    function automatic arb_state_t own_state(input logic owner_is_core);
        arb_state_t st;
        if (owner_is_core) begin
            st = ST_OWN_CORE;
        end else begin
            st = ST_OWN_IO;
        end
        return st;
    endfunction

endpackage

// File: rtl/ram_access_arbiter_if.sv
// Requester-side and RAM-side signals of the two-client RAM arbiter.
interface ram_access_arbiter_if import ode_mem_pkg::*; #(
    parameter int AW = DEFAULT_AW,
    parameter int DW = DEFAULT_DW
);

    logic [1:0]        Req;
    logic [1:0]        Grant;
    logic [1:0]        Preempt;
    logic [1:0]        WR_En;
    logic [2*AW-1:0]   WR_Address;
    logic [2*DW-1:0]   WR_Data;
    logic [2*AW-1:0]   RD1_Address;
    logic [2*AW-1:0]   RD2_Address;
    logic              RAM_WR_Enable;
    logic [AW-1:0]     RAM_WR_Address;
    logic [DW-1:0]     RAM_WR_Data;
    logic [AW-1:0]     RAM_RD1_Address;
    logic [AW-1:0]     RAM_RD2_Address;
    logic [1:0]        RD_Valid;

    modport slave (
        input  Req, WR_En, WR_Address, WR_Data, RD1_Address, RD2_Address,
        output Grant, Preempt, RD_Valid,
        output RAM_WR_Enable, RAM_WR_Address, RAM_WR_Data, RAM_RD1_Address, RAM_RD2_Address
    );

    modport master (
        output Req, WR_En, WR_Address, WR_Data, RD1_Address, RD2_Address,
        input  Grant, Preempt, RD_Valid,
        input  RAM_WR_Enable, RAM_WR_Address, RAM_WR_Data, RAM_RD1_Address, RAM_RD2_Address
    );

endinterface

// File: rtl/ram_hold_timer.sv
// Counts grant cycles during which the non-owning requester is waiting and
// flags the cycle in which the owner must be forced off the RAM.
module ram_hold_timer import ode_mem_pkg::*; #(
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic other_waiting,
    output logic expire
);

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

    logic [7:0] hold_cnt_r;

    // Saturating wait counter, restarted on every ownership change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_r <= 8'd0;
        end else if (clear) begin
            hold_cnt_r <= 8'd0;
        end else if (other_waiting && (hold_cnt_r != 8'hFF)) begin
            hold_cnt_r <= hold_cnt_r + 8'd1;
        end else begin
            hold_cnt_r <= hold_cnt_r;
        end
    end

    assign expire = other_waiting && (hold_cnt_r == HOLD_LIMIT);

endmodule

// File: rtl/ram_access_arbiter.sv
// Two-client arbiter (IO module, solver core) for a shared synchronous RAM
// with round-robin tie-break, bounded hold time and read-valid tracking.
module ram_access_arbiter import ode_mem_pkg::*; #(
    parameter int RAM_ADDRESS_WIDTH = DEFAULT_AW,
    parameter int DATA_WIDTH        = DEFAULT_DW,
    parameter int MAX_HOLD          = DEFAULT_MAX_HOLD
) (
    input logic                CLK,
    input logic                RST,
    ram_access_arbiter_if.slave bus
);

    localparam int AW = RAM_ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;

    arb_state_t    state_r;
    arb_state_t    state_next_s;
    logic          state_change_s;
    logic          last_core_r;
    logic          ready_r;
    logic [1:0]    preempt_r;
    logic [1:0]    preempt_next_s;
    logic [1:0]    rd_valid_r;
    logic          other_waiting_s;
    logic          expire_s;

    logic          ram_we_s;
    logic [AW-1:0] ram_wa_s;
    logic [DW-1:0] ram_wd_s;
    logic [AW-1:0] ram_ra1_s;
    logic [AW-1:0] ram_ra2_s;

    assign other_waiting_s = ((state_r == ST_OWN_IO)   && bus.Req[OWNER_CORE]) ||
                             ((state_r == ST_OWN_CORE) && bus.Req[OWNER_IO]);

    ram_hold_timer #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold_timer (
        .clk           (CLK),
        .rst_n         (RST),
        .clear         (state_change_s),
        .other_waiting (other_waiting_s),
        .expire        (expire_s)
    );

    // Ownership transitions: release, direct handoff, forced preemption.
    always_comb begin
        state_next_s   = state_r;
        preempt_next_s = 2'b00;
        case (state_r)
            ST_IDLE: begin
                // ready_r holds IDLE through the first edge after reset release.
                if (!ready_r) begin
                    state_next_s = ST_IDLE;
                end else if (bus.Req == 2'b11) begin
                    state_next_s = own_state(~last_core_r);
                end else if (bus.Req[OWNER_IO]) begin
                    state_next_s = ST_OWN_IO;
                end else if (bus.Req[OWNER_CORE]) begin
                    state_next_s = ST_OWN_CORE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_OWN_IO: begin
                if (!bus.Req[OWNER_IO]) begin
                    state_next_s = bus.Req[OWNER_CORE] ? ST_OWN_CORE : ST_IDLE;
                end else if (expire_s) begin
                    state_next_s             = ST_OWN_CORE;
                    preempt_next_s[OWNER_IO] = 1'b1;
                end else begin
                    state_next_s = ST_OWN_IO;
                end
            end
            ST_OWN_CORE: begin
                if (!bus.Req[OWNER_CORE]) begin
                    state_next_s = bus.Req[OWNER_IO] ? ST_OWN_IO : ST_IDLE;
                end else if (expire_s) begin
                    state_next_s               = ST_OWN_IO;
                    preempt_next_s[OWNER_CORE] = 1'b1;
                end else begin
                    state_next_s = ST_OWN_CORE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    assign state_change_s = (state_next_s != state_r);

    // State, preempt pulse and read-valid pipeline (RAM read latency is one cycle).
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r    <= ST_IDLE;
            ready_r    <= 1'b0;
            preempt_r  <= 2'b00;
            rd_valid_r <= 2'b00;
        end else begin
            state_r    <= state_next_s;
            ready_r    <= 1'b1;
            preempt_r  <= preempt_next_s;
            rd_valid_r <= state_r;
        end
    end

    // Round-robin pointer remembers the last owner; reset value favours IO.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            last_core_r <= 1'b1;
        end else if (state_change_s && (state_next_s != ST_IDLE)) begin
            last_core_r <= (state_next_s == ST_OWN_CORE);
        end else begin
            last_core_r <= last_core_r;
        end
    end

    // RAM bus follows the owner; writes are gated by the grant itself.
    always_comb begin
        ram_we_s  = 1'b0;
        ram_wa_s  = {AW{1'b0}};
        ram_wd_s  = {DW{1'b0}};
        ram_ra1_s = {AW{1'b0}};
        ram_ra2_s = {AW{1'b0}};
        case (state_r)
            ST_OWN_IO: begin
                ram_we_s  = bus.WR_En[OWNER_IO] & state_r[OWNER_IO];
                ram_wa_s  = bus.WR_Address[OWNER_IO*AW +: AW];
                ram_wd_s  = bus.WR_Data[OWNER_IO*DW +: DW];
                ram_ra1_s = bus.RD1_Address[OWNER_IO*AW +: AW];
                ram_ra2_s = bus.RD2_Address[OWNER_IO*AW +: AW];
            end
            ST_OWN_CORE: begin
                ram_we_s  = bus.WR_En[OWNER_CORE] & state_r[OWNER_CORE];
                ram_wa_s  = bus.WR_Address[OWNER_CORE*AW +: AW];
                ram_wd_s  = bus.WR_Data[OWNER_CORE*DW +: DW];
                ram_ra1_s = bus.RD1_Address[OWNER_CORE*AW +: AW];
                ram_ra2_s = bus.RD2_Address[OWNER_CORE*AW +: AW];
            end
            default: begin
                ram_we_s = 1'b0;
            end
        endcase
    end

    assign bus.Grant           = state_r;
    assign bus.Preempt         = preempt_r;
    assign bus.RD_Valid        = rd_valid_r;
    assign bus.RAM_WR_Enable   = ram_we_s;
    assign bus.RAM_WR_Address  = ram_wa_s;
    assign bus.RAM_WR_Data     = ram_wd_s;
    assign bus.RAM_RD1_Address = ram_ra1_s;
    assign bus.RAM_RD2_Address = ram_ra2_s;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed and randomized bench for ram_access_arbiter against an ownership
// model kept as plain integers plus an expected-memory image.
module tb_ram_access_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int MAX_HOLD = 4;

    logic clk;
    logic rst;

    ram_access_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    ram_access_arbiter #(
        .RAM_ADDRESS_WIDTH (AW),
        .DATA_WIDTH        (DW),
        .MAX_HOLD          (MAX_HOLD)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM written from the arbiter's RAM port.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.RAM_WR_Enable) ram[bus.RAM_WR_Address] <= bus.RAM_WR_Data;
    end

    int pass_count = 0;
    int fail_count = 0;
    int check_count = 0;

    logic [1:0]    req_v;
    logic [1:0]    we_v;
    logic [AW-1:0] wa_v [2];
    logic [DW-1:0] wd_v [2];
    logic [AW-1:0] r1_v [2];
    logic [AW-1:0] r2_v [2];

    // Reference model: owner -1 = nobody, 0 = IO, 1 = core.
    int            mdl_owner;
    int            mdl_last;
    int            mdl_waited;
    bit            mdl_ready;
    logic [1:0]    mdl_pre;
    logic [1:0]    mdl_rdv;
    logic [DW-1:0] exp_mem [0:(1<<AW)-1];
    bit            mdl_wrote;
    logic [AW-1:0] mdl_wr_at;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        check_count++;
        assert (obs === expv) pass_count++;
        else begin
            fail_count++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [1:0] grant_of(input int o);
        logic [1:0] g;
        if (o < 0) g = 2'b00;
        else if (o == 0) g = 2'b01;
        else g = 2'b10;
        return g;
    endfunction

    task automatic model_reset();
        mdl_owner = -1;
        mdl_last = 1;
        mdl_waited = 0;
        mdl_ready = 1'b0;
        mdl_pre = 2'b00;
        mdl_rdv = 2'b00;
        mdl_wrote = 1'b0;
    endtask

    task automatic model_edge();
        int nxt;
        int other;
        logic [1:0] pre_n;
        pre_n = 2'b00;
        mdl_wrote = 1'b0;
        if (mdl_owner >= 0 && we_v[mdl_owner]) begin
            exp_mem[wa_v[mdl_owner]] = wd_v[mdl_owner];
            mdl_wrote = 1'b1;
            mdl_wr_at = wa_v[mdl_owner];
        end
        if (!mdl_ready) begin
            nxt = -1;
            mdl_ready = 1'b1;
        end else if (mdl_owner < 0) begin
            if (req_v == 2'b11) nxt = 1 - mdl_last;
            else if (req_v[0]) nxt = 0;
            else if (req_v[1]) nxt = 1;
            else nxt = -1;
        end else begin
            other = 1 - mdl_owner;
            if (!req_v[mdl_owner]) nxt = req_v[other] ? other : -1;
            else if (req_v[other] && (mdl_waited + 1 >= MAX_HOLD)) begin
                nxt = other;
                pre_n[mdl_owner] = 1'b1;
            end else nxt = mdl_owner;
        end
        mdl_rdv = grant_of(mdl_owner);
        if (nxt != mdl_owner) mdl_waited = 0;
        else if (mdl_owner >= 0 && req_v[1 - mdl_owner]) mdl_waited++;
        if (nxt >= 0) mdl_last = nxt;
        mdl_owner = nxt;
        mdl_pre = pre_n;
    endtask

    task automatic drive();
        bus.Req         = req_v;
        bus.WR_En       = we_v;
        bus.WR_Address  = {wa_v[1], wa_v[0]};
        bus.WR_Data     = {wd_v[1], wd_v[0]};
        bus.RD1_Address = {r1_v[1], r1_v[0]};
        bus.RD2_Address = {r2_v[1], r2_v[0]};
    endtask

    task automatic check_outputs();
        logic          e_we;
        logic [AW-1:0] e_wa;
        logic [DW-1:0] e_wd;
        logic [AW-1:0] e_r1;
        logic [AW-1:0] e_r2;
        if (mdl_owner < 0) begin
            e_we = 1'b0; e_wa = '0; e_wd = '0; e_r1 = '0; e_r2 = '0;
        end else begin
            e_we = we_v[mdl_owner];
            e_wa = wa_v[mdl_owner];
            e_wd = wd_v[mdl_owner];
            e_r1 = r1_v[mdl_owner];
            e_r2 = r2_v[mdl_owner];
        end
        check("grant",    64'(bus.Grant),           64'(grant_of(mdl_owner)));
        check("preempt",  64'(bus.Preempt),         64'(mdl_pre));
        check("rd_valid", 64'(bus.RD_Valid),        64'(mdl_rdv));
        check("ram_we",   64'(bus.RAM_WR_Enable),   64'(e_we));
        check("ram_wa",   64'(bus.RAM_WR_Address),  64'(e_wa));
        check("ram_wd",   64'(bus.RAM_WR_Data),     64'(e_wd));
        check("ram_ra1",  64'(bus.RAM_RD1_Address), 64'(e_r1));
        check("ram_ra2",  64'(bus.RAM_RD2_Address), 64'(e_r2));
    endtask

    // One clock cycle: drive, check before the edge, advance model at the edge.
    task automatic step();
        drive();
        #2;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
        if (mdl_wrote) check("mem_write", 64'(ram[mdl_wr_at]), 64'(exp_mem[mdl_wr_at]));
    endtask

    // Reset asserted between edges, held across one edge, released after it.
    task automatic pulse_reset();
        drive();
        #2;
        check_outputs();
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        check("grant_in_reset", 64'(bus.Grant), 64'h0);
        rst = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int held_cycles;
        bit switched;
        req_v = 2'b00; we_v = 2'b00;
        for (int i = 0; i < 2; i++) begin
            wa_v[i] = '0; wd_v[i] = '0; r1_v[i] = '0; r2_v[i] = '0;
        end
        rst = 1'b0;
        model_reset();
        drive();
        #2;
        check_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single IO request: grant after one edge, write reaches RAM.
        step();
        req_v = 2'b01; we_v = 2'b01; wa_v[0] = 13'h0ABC; wd_v[0] = 32'h1234_5678;
        step();
        drive();
        #1;
        check("io_grant_c1", 64'(bus.Grant), 64'h1);
        check("io_waddr", 64'(bus.RAM_WR_Address), 64'h0ABC);
        step();
        check("io_write_lands", 64'(ram[13'h0ABC]), 64'h1234_5678);
        req_v = 2'b00; we_v = 2'b00;
        step();

        // Simultaneous requests from reset: IO first, then direct handoff.
        req_v = 2'b11;
        pulse_reset();
        step();
        step();
        check("tie_favours_io", 64'(bus.Grant), 64'h1);
        req_v = 2'b10;
        step();
        check("handoff_to_core", 64'(bus.Grant), 64'h2);

        // Preemption after MAX_HOLD cycles of the other requester waiting.
        req_v = 2'b00;
        step();
        req_v = 2'b01;
        step();
        req_v = 2'b11;
        held_cycles = 0;
        switched = 1'b0;
        for (int i = 0; i < 20 && !switched; i++) begin
            drive();
            #1;
            if (bus.Grant === 2'b01) begin
                held_cycles++;
                step();
            end else begin
                switched = 1'b1;
            end
        end
        check("hold_limit_cycles", 64'(held_cycles), 64'd4);
        check("preempt_grant", 64'(bus.Grant), 64'h2);
        check("preempt_pulse", 64'(bus.Preempt), 64'h1);
        step();
        check("preempt_clears", 64'(bus.Preempt), 64'h0);

        // Non-granted writer is ignored.
        req_v = 2'b01;
        step();
        we_v = 2'b01; wa_v[0] = 13'h0005; wd_v[0] = 32'hA5A5_0001;
        step();
        we_v = 2'b10; wa_v[1] = 13'h0005; wd_v[1] = 32'hDEAD_BEEF;
        step();
        check("foreign_write_blocked", 64'(ram[13'h0005]), 64'hA5A5_0001);

        // Reset mid-write, then core request granted on the second edge.
        we_v = 2'b01; wa_v[0] = 13'h0123; wd_v[0] = 32'h0BAD_F00D;
        drive();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("reset_grant_now", 64'(bus.Grant), 64'h0);
        check("reset_we_now", 64'(bus.RAM_WR_Enable), 64'h0);
        check_outputs();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_v = 2'b10; we_v = 2'b00;
        step();
        check("no_grant_first_edge", 64'(bus.Grant), 64'h0);
        step();
        check("grant_second_edge", 64'(bus.Grant), 64'h2);

        // Read-valid follows the grant by one cycle, across a handoff.
        r1_v[1] = 13'h0011; r2_v[1] = 13'h0022; r1_v[0] = 13'h0033; r2_v[0] = 13'h0044;
        step();
        check("rd_valid_core", 64'(bus.RD_Valid), 64'h2);
        req_v = 2'b01;
        step();
        check("handoff_grant_io", 64'(bus.Grant), 64'h1);
        check("rd_valid_after_handoff", 64'(bus.RD_Valid), 64'h2);
        step();
        check("rd_valid_io", 64'(bus.RD_Valid), 64'h1);

        // Drop-and-reraise is a fresh request under round-robin.
        req_v = 2'b00;
        step();
        req_v = 2'b11;
        step();
        check("reraise_round_robin", 64'(bus.Grant), 64'h2);

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 4) == 0) req_v[0] = ~req_v[0];
            if ($urandom_range(0, 4) == 0) req_v[1] = ~req_v[1];
            we_v = 2'($urandom_range(0, 3));
            for (int i = 0; i < 2; i++) begin
                wa_v[i] = 13'($urandom_range(0, 31));
                wd_v[i] = $urandom;
                r1_v[i] = 13'($urandom_range(0, 8191));
                r2_v[i] = 13'($urandom_range(0, 8191));
            end
            if ($urandom_range(0, 99) == 0) pulse_reset();
            else step();
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
